// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cacheline adapter.
// The top module's optional address checker is enabled with CACHELINE_ADAPTER_ADDR_CHECK_EN.
package cacheline_adapter_types;

   localparam int BEATS         = 4;
   localparam int BEAT_IDX_W    = 2;
   localparam int LINE_OFFSET_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      RD_RESP,
      WR_DATA
   } cl_adapter_state_t;

endpackage : cacheline_adapter_types

// File: rtl/cacheline_adapter_burst_line_buffer.sv
// One cacheline of storage shared by both directions.
// Reads assemble it beat by beat; writes load it whole and drain it beat by beat.
module burst_line_buffer #(
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  beat_load_i,
   input  logic [IDX_W-1:0]      beat_idx_i,
   input  logic [BEAT_WIDTH-1:0] beat_data_i,
   input  logic                  line_load_i,
   input  logic [LINE_WIDTH-1:0] line_data_i,
   output logic [LINE_WIDTH-1:0] line_o,
   output logic [BEAT_WIDTH-1:0] beat_o
);

   logic [LINE_WIDTH-1:0] line_q;

   // NOTE: pure data storage carries no reset; the control FSM guarantees it is
   // fully written before any of it reaches an output.
   always_ff @(posedge clk) begin
      if (line_load_i) begin
         line_q <= line_data_i;
      end else if (beat_load_i) begin
         line_q[BEAT_WIDTH*beat_idx_i +: BEAT_WIDTH] <= beat_data_i;
      end
   end

   assign line_o = line_q;
   assign beat_o = line_q[BEAT_WIDTH*beat_idx_i +: BEAT_WIDTH];

endmodule : burst_line_buffer

// File: rtl/cacheline_adapter.sv
// Converts whole-cacheline read/write requests into 4-beat bursts on the bmem port.
// Define CACHELINE_ADAPTER_ADDR_CHECK_EN to enable the sticky protocol error flag.
module cacheline_adapter
   import cacheline_adapter_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] ufp_addr,
   input  logic                  ufp_read,
   input  logic                  ufp_write,
   input  logic [LINE_WIDTH-1:0] ufp_wdata,
   output logic                  ufp_ready,
   output logic [ADDR_WIDTH-1:0] ufp_raddr,
   output logic [LINE_WIDTH-1:0] ufp_rdata,
   output logic                  ufp_rvalid,
   output logic [ADDR_WIDTH-1:0] bmem_addr,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic                  bmem_ready,
   input  logic [ADDR_WIDTH-1:0] bmem_raddr,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_rvalid,
   output logic                  err
);

   cl_adapter_state_t     state_q, state_d;
   logic [BEAT_IDX_W-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic                  last_beat;
   logic                  beat_load;
   logic                  line_load;
   logic [LINE_WIDTH-1:0] buf_line;
   logic [BEAT_WIDTH-1:0] buf_beat;

   assign line_addr = {ufp_addr[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
   assign last_beat = (cnt_q == BEAT_IDX_W'(BEATS - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its pre-edge value regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   // All outputs decode from the registered state, so an async reset drops them at once.
   always_comb begin
      // NOTE: every signal gets a default first; a path that forgot one would infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      beat_load  = 1'b0;
      line_load  = 1'b0;
      ufp_ready  = 1'b0;
      ufp_rvalid = 1'b0;
      ufp_raddr  = '0;
      ufp_rdata  = '0;
      bmem_addr  = '0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            ufp_ready = 1'b1;
            if (ufp_write) begin
               addr_d    = line_addr;
               line_load = 1'b1;
               cnt_d     = '0;
               state_d   = WR_DATA;
            end else if (ufp_read) begin
               addr_d  = line_addr;
               cnt_d   = '0;
               state_d = RD_REQ;
            end
         end

         RD_REQ: begin
            bmem_read = 1'b1;
            bmem_addr = addr_q;
            if (bmem_ready) begin
               state_d = RD_DATA;
            end
         end

         RD_DATA: begin
            bmem_addr = addr_q;
            if (bmem_rvalid) begin
               beat_load = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = RD_RESP;
               end
            end
         end

         RD_RESP: begin
            ufp_rvalid = 1'b1;
            ufp_raddr  = addr_q;
            ufp_rdata  = buf_line;
            state_d    = IDLE;
         end

         WR_DATA: begin
            bmem_write = 1'b1;
            bmem_addr  = addr_q;
            bmem_wdata = buf_beat;
            if (bmem_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   burst_line_buffer #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .IDX_W      (BEAT_IDX_W)
   ) u_line_buf (
      .clk         (clk),
      .beat_load_i (beat_load),
      .beat_idx_i  (cnt_q),
      .beat_data_i (bmem_rdata),
      .line_load_i (line_load),
      .line_data_i (ufp_wdata),
      .line_o      (buf_line),
      .beat_o      (buf_beat)
   );

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
   logic err_q;
   logic err_set;

   // A mismatched beat is still stored; the flag only records that it happened.
   always_comb begin
      err_set = 1'b0;
      if ((state_q == RD_DATA) && bmem_rvalid && (bmem_raddr != addr_q)) begin
         err_set = 1'b1;
      end
      if ((state_q == IDLE) && ufp_read && ufp_write) begin
         err_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | err_set;
      end
   end

   assign err = err_q;
`else
   logic unused_raddr;

   assign unused_raddr = ^bmem_raddr;
   assign err          = 1'b0;
`endif

endmodule : cacheline_adapter

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: expected read lines and write beats are
// queued when requests are driven and retired when the DUT presents them.
module tb_cacheline_adapter;

   localparam int AW = 32;
   localparam int LW = 256;
   localparam int BW = 64;

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] ufp_addr = '0;
   logic          ufp_read = 1'b0;
   logic          ufp_write = 1'b0;
   logic [LW-1:0] ufp_wdata = '0;
   logic          ufp_ready;
   logic [AW-1:0] ufp_raddr;
   logic [LW-1:0] ufp_rdata;
   logic          ufp_rvalid;
   logic [AW-1:0] bmem_addr;
   logic          bmem_read;
   logic          bmem_write;
   logic [BW-1:0] bmem_wdata;
   logic          bmem_ready = 1'b0;
   logic [AW-1:0] bmem_raddr = '0;
   logic [BW-1:0] bmem_rdata = '0;
   logic          bmem_rvalid = 1'b0;
   logic          err;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [LW-1:0] line;
   } rd_exp_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [BW-1:0] beat;
   } wr_exp_t;

   rd_exp_t rd_q[$];
   wr_exp_t wr_q[$];

   int n_vec = 0;
   int n_miscmp = 0;

   always #5 clk = ~clk;

   cacheline_adapter #(
      .ADDR_WIDTH (AW),
      .LINE_WIDTH (LW),
      .BEAT_WIDTH (BW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ufp_addr    (ufp_addr),
      .ufp_read    (ufp_read),
      .ufp_write   (ufp_write),
      .ufp_wdata   (ufp_wdata),
      .ufp_ready   (ufp_ready),
      .ufp_raddr   (ufp_raddr),
      .ufp_rdata   (ufp_rdata),
      .ufp_rvalid  (ufp_rvalid),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid),
      .err         (err)
   );

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: retire expectations as the DUT presents lines and beats.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ufp_rvalid) begin
            if (rd_q.size() == 0) begin
               check("rvalid_unexpected", LW'(ufp_rvalid), LW'(0));
            end else begin
               rd_exp_t e;
               e = rd_q.pop_front();
               check("rd_raddr", LW'(ufp_raddr), LW'(e.addr));
               check("rd_rdata", ufp_rdata, e.line);
            end
         end
         if (bmem_write && bmem_ready) begin
            if (wr_q.size() == 0) begin
               check("wr_unexpected", LW'(bmem_write), LW'(0));
            end else begin
               wr_exp_t w;
               w = wr_q.pop_front();
               check("wr_addr", LW'(bmem_addr), LW'(w.addr));
               check("wr_beat", LW'(bmem_wdata), LW'(w.beat));
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Starts in an IDLE cycle; returns in the IDLE cycle right after the rvalid pulse.
   task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int bad_beat);
      logic [AW-1:0] la;
      int            n;
      la = {addr[AW-1:5], 5'b0};
      rd_q.push_back('{addr: la, line: line});
      ufp_addr = addr;
      ufp_read = 1'b1;
      next_cycle();
      ufp_read = 1'b0;
      check("rd_req_read", LW'(bmem_read), LW'(1));
      check("rd_req_addr", LW'(bmem_addr), LW'(la));
      check("rd_req_ready", LW'(ufp_ready), LW'(0));
      bmem_ready = 1'b1;
      next_cycle();
      bmem_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bmem_rvalid = 1'b1;
         bmem_rdata  = line[BW*b +: BW];
         bmem_raddr  = (b == bad_beat) ? la + 32'h20 : la;
         next_cycle();
      end
      bmem_rvalid = 1'b0;
      n = 0;
      while (!ufp_rvalid && n < 8) begin
         next_cycle();
         n++;
      end
      check("rd_latency", LW'(n), LW'(0));
      next_cycle();
      check("rd_after_rvalid", LW'(ufp_rvalid), LW'(0));
      check("rd_ready_back", LW'(ufp_ready), LW'(1));
   endtask

   // Starts in an IDLE cycle; pat supplies bmem_ready per WR_DATA cycle (LSB first),
   // then ready stays high. Returns in the cycle after the last beat is accepted.
   task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                           input logic [15:0] pat, input int pat_len, input logic also_read);
      logic [AW-1:0] la;
      int            acc;
      int            cyc;
      logic          r;
      la = {addr[AW-1:5], 5'b0};
      for (int b = 0; b < 4; b++) begin
         wr_q.push_back('{addr: la, beat: line[BW*b +: BW]});
      end
      ufp_addr  = addr;
      ufp_wdata = line;
      ufp_write = 1'b1;
      ufp_read  = also_read;
      next_cycle();
      ufp_write = 1'b0;
      ufp_read  = 1'b0;
      ufp_wdata = '0;
      acc = 0;
      cyc = 0;
      while (acc < 4 && cyc < 32) begin
         r = (cyc < pat_len) ? pat[cyc] : 1'b1;
         bmem_ready = r;
         check("wr_valid", LW'(bmem_write), LW'(1));
         check("wr_hold_beat", LW'(bmem_wdata), LW'(line[BW*acc +: BW]));
         check("wr_no_read", LW'(bmem_read), LW'(0));
         next_cycle();
         if (r) acc++;
         cyc++;
      end
      bmem_ready = 1'b0;
      check("wr_all_accepted", LW'(acc), LW'(4));
      check("wr_ready_back", LW'(ufp_ready), LW'(1));
      check("wr_write_low", LW'(bmem_write), LW'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, LW'(ufp_ready), LW'(1));
      check({tag, "_rvalid"}, LW'(ufp_rvalid), LW'(0));
      check({tag, "_bread"}, LW'(bmem_read), LW'(0));
      check({tag, "_bwrite"}, LW'(bmem_write), LW'(0));
      check({tag, "_baddr"}, LW'(bmem_addr), LW'(0));
      check({tag, "_bwdata"}, LW'(bmem_wdata), LW'(0));
      check({tag, "_raddr"}, LW'(ufp_raddr), LW'(0));
      check({tag, "_rdata"}, ufp_rdata, LW'(0));
      check({tag, "_err"}, LW'(err), LW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [LW-1:0] line_a;
      logic [LW-1:0] line_b;
      logic [LW-1:0] line_c;
      logic [LW-1:0] line_d;
      line_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      line_b = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
                64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
      line_c = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      line_d = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      rst_n = 1'b1;
      next_cycle();
      check_reset_outputs("rst_done");

      // Basic read with unaligned request address.
      do_read(32'h0000_1234, line_a, -1);

      // Write with stalls on bmem_ready: 1,0,1,1,0,1.
      do_write(32'h8000_0040, line_b, 16'b10_1101, 6, 1'b0);

      // Read followed immediately by a write in the cycle after rvalid.
      do_read(32'h0000_3360, line_c, -1);
      do_write(32'h0000_4000, line_d, 16'h0, 0, 1'b0);

      // Stray read beats while idle are ignored.
      for (int i = 0; i < 2; i++) begin
         bmem_rvalid = 1'b1;
         bmem_rdata  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
         next_cycle();
         check("stray_ready", LW'(ufp_ready), LW'(1));
         check("stray_bread", LW'(bmem_read), LW'(0));
      end
      bmem_rvalid = 1'b0;

      // Reset in the middle of a read burst, after two beats.
      ufp_addr = 32'h0000_2008;
      ufp_read = 1'b1;
      next_cycle();
      ufp_read   = 1'b0;
      bmem_ready = 1'b1;
      next_cycle();
      bmem_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bmem_rvalid = 1'b1;
         bmem_rdata  = 64'h5555_0000_0000_0000 | 64'(b);
         bmem_raddr  = 32'h0000_2000;
         next_cycle();
      end
      bmem_rvalid = 1'b0;
      check("mid_burst_addr", LW'(bmem_addr), LW'(32'h0000_2000));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bmem_rvalid = 1'b1;
         bmem_rdata  = 64'h6666_0000_0000_0000 | 64'(i);
         next_cycle();
         check("stale_ready", LW'(ufp_ready), LW'(1));
      end
      bmem_rvalid = 1'b0;
      do_read(32'h0000_2000, line_d, -1);

      // Address-tag mismatch on beat 2; the line is still returned intact.
      do_read(32'h0000_1234, line_a, 2);
      check("err_after_mismatch", LW'(err), LW'(EXP_ERR));
      do_read(32'h0000_5000, line_c, -1);
      check("err_sticky", LW'(err), LW'(EXP_ERR));
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      check("err_cleared", LW'(err), LW'(0));

      // Read and write together: the write wins and the read is dropped.
      next_cycle();
      do_write(32'h0000_6020, line_c, 16'h0, 0, 1'b1);
      check("err_both_req", LW'(err), LW'(EXP_ERR));
      next_cycle();
      check("both_req_no_read", LW'(bmem_read), LW'(0));

      repeat (3) next_cycle();
      check("rd_queue_drained", LW'(rd_q.size()), LW'(0));
      check("wr_queue_drained", LW'(wr_q.size()), LW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule : tb_cacheline_adapter
